// File: rtl/inner_sink_chk.sv
// inner_sink_chk -- receive-side checker for the inner-source test-pattern
// stream. Regenerates the expected word sequence from the init/step/length
// configuration and compares every received word against it.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   init_dat, step_dat         pattern initial byte and byte step
//   update_flag                level-held config-load request (async)
//   dat_length                 frame length in bytes (words = [15:1], min 1)
//   din, en_in                 received word and its valid strobe
//   busy                       checker armed / mid-frame
//   frame_done, frame_err      one-cycle end-of-frame pulse and its error flag
//   err_cnt, word_cnt, frame_cnt  running counters since the last load
//   first_err_*                capture of the first mismatch since load
//
// Optional feature: define INNER_SINK_ERR_CAPTURE_EN to build the first-error
// capture registers; otherwise first_err_* are tied to 0.
module inner_sink_chk (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  init_dat,
  input  logic [7:0]  step_dat,
  input  logic        update_flag,
  input  logic [15:0] dat_length,
  input  logic [15:0] din,
  input  logic        en_in,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] err_cnt,
  output logic [15:0] word_cnt,
  output logic [15:0] frame_cnt,
  output logic [15:0] first_err_idx,
  output logic [15:0] first_err_exp,
  output logic [15:0] first_err_got,
  output logic        first_err_vld
);

  typedef enum logic {IDLE, CHECK} state_e;

  state_e      state_q, state_d;
  logic        flag0_q, flag1_q;
  logic [7:0]  base_hi_q, base_hi_d;
  logic [7:0]  base_lo_q, base_lo_d;
  logic [7:0]  step2_q, step2_d;
  logic [15:0] len_w_q, len_w_d;
  logic [7:0]  exp_hi_q, exp_hi_d;
  logic [7:0]  exp_lo_q, exp_lo_d;
  logic [15:0] idx_q, idx_d;
  logic        sticky_q, sticky_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic [15:0] len_half;
  logic        fire;   // a word is being checked this cycle
  logic        mism;   // that word differs from the expected one

  // Shifting the whole vectors keeps every input bit referenced; the dropped
  // LSB of the length and MSB of the doubled step are intentional.
  assign len_half = dat_length >> 1;
  assign fire     = !flag0_q && (state_q == CHECK) && en_in;
  assign mism     = (din != {exp_hi_q, exp_lo_q});

  always_comb begin
    // NOTE: every next-state value defaults to its current value first so no
    // path through the branches below leaves a signal unassigned (no latches).
    state_d      = state_q;
    base_hi_d    = base_hi_q;
    base_lo_d    = base_lo_q;
    step2_d      = step2_q;
    len_w_d      = len_w_q;
    exp_hi_d     = exp_hi_q;
    exp_lo_d     = exp_lo_q;
    idx_d        = idx_q;
    sticky_d     = sticky_q;
    err_cnt_d    = err_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (flag0_q) begin
      // Update in progress: abort any frame, clear the statistics, and latch
      // the configuration once the request has been seen for two cycles.
      state_d     = IDLE;
      sticky_d    = 1'b0;
      err_cnt_d   = '0;
      word_cnt_d  = '0;
      frame_cnt_d = '0;
      if (flag1_q) begin
        base_hi_d = init_dat;
        base_lo_d = init_dat + step_dat;
        step2_d   = step_dat << 1;
        len_w_d   = (len_half == 16'd0) ? 16'd1 : len_half;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // Falling edge of the synchronised update arms the checker.
          if (flag1_q) begin
            exp_hi_d = base_hi_q;
            exp_lo_d = base_lo_q;
            idx_d    = '0;
            sticky_d = 1'b0;
            state_d  = CHECK;
          end
        end
        CHECK: begin
          if (en_in) begin
            if (mism && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            exp_hi_d   = exp_hi_q + step2_q;
            exp_lo_d   = exp_lo_q + step2_q;
            idx_d      = idx_q + 16'd1;
            word_cnt_d = word_cnt_q + 16'd1;
            sticky_d   = sticky_q | mism;
            if (idx_q == len_w_q - 16'd1) begin
              frame_done_d = 1'b1;
              frame_err_d  = sticky_q | mism;
              sticky_d     = 1'b0;
              exp_hi_d     = base_hi_q;
              exp_lo_d     = base_lo_q;
              idx_d        = '0;
              frame_cnt_d  = frame_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      flag0_q      <= 1'b0;
      flag1_q      <= 1'b0;
      base_hi_q    <= '0;
      base_lo_q    <= '0;
      step2_q      <= 8'd2;
      len_w_q      <= 16'd1;
      exp_hi_q     <= '0;
      exp_lo_q     <= '0;
      idx_q        <= '0;
      sticky_q     <= 1'b0;
      err_cnt_q    <= '0;
      word_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag0_q      <= update_flag;
      flag1_q      <= flag0_q;
      base_hi_q    <= base_hi_d;
      base_lo_q    <= base_lo_d;
      step2_q      <= step2_d;
      len_w_q      <= len_w_d;
      exp_hi_q     <= exp_hi_d;
      exp_lo_q     <= exp_lo_d;
      idx_q        <= idx_d;
      sticky_q     <= sticky_d;
      err_cnt_q    <= err_cnt_d;
      word_cnt_q   <= word_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign busy       = (state_q == CHECK);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign word_cnt   = word_cnt_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef INNER_SINK_ERR_CAPTURE_EN
  logic [15:0] cap_idx_q, cap_exp_q, cap_got_q;
  logic        cap_vld_q;

  // Only the first mismatch after a load is kept.
  always_ff @(posedge clk) begin
    if (reset || flag0_q) begin
      cap_idx_q <= '0;
      cap_exp_q <= '0;
      cap_got_q <= '0;
      cap_vld_q <= 1'b0;
    end else if (fire && mism && !cap_vld_q) begin
      cap_idx_q <= idx_q;
      cap_exp_q <= {exp_hi_q, exp_lo_q};
      cap_got_q <= din;
      cap_vld_q <= 1'b1;
    end
  end

  assign first_err_idx = cap_idx_q;
  assign first_err_exp = cap_exp_q;
  assign first_err_got = cap_got_q;
  assign first_err_vld = cap_vld_q;
`else
  logic unused_fire;
  assign unused_fire   = fire;
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_got = '0;
  assign first_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_inner_sink_chk.sv
// Self-checking bench for inner_sink_chk: directed scenarios plus a randomized
// section, all compared against an arithmetic model of the pattern stream.
module tb_inner_sink_chk;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  init_dat, step_dat;
  logic        update_flag;
  logic [15:0] dat_length, din;
  logic        en_in;
  logic        busy, frame_done, frame_err, first_err_vld;
  logic [15:0] err_cnt, word_cnt, frame_cnt;
  logic [15:0] first_err_idx, first_err_exp, first_err_got;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0]  m_init, m_step;
  int unsigned m_lenw, m_idx;
  logic        m_armed, m_sticky, m_done, m_ferr;
  logic [15:0] m_err, m_words, m_frames;
  logic        m_cvld;
  logic [15:0] m_cidx, m_cexp, m_cgot;

  inner_sink_chk dut (
    .clk(clk), .reset(reset), .init_dat(init_dat), .step_dat(step_dat),
    .update_flag(update_flag), .dat_length(dat_length), .din(din), .en_in(en_in),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .err_cnt(err_cnt), .word_cnt(word_cnt), .frame_cnt(frame_cnt),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .first_err_vld(first_err_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected word k of a frame: each byte advances by twice the step per word.
  function automatic logic [15:0] exp_word(int unsigned k);
    logic [7:0] s2, hi, lo;
    s2 = 8'(m_step * 2);
    hi = 8'(m_init + k * s2);
    lo = 8'(m_init + m_step + k * s2);
    return {hi, lo};
  endfunction

  task automatic model_clear();
    m_idx = 0; m_sticky = 0; m_done = 0; m_ferr = 0;
    m_err = 0; m_words = 0; m_frames = 0;
    m_cvld = 0; m_cidx = 0; m_cexp = 0; m_cgot = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},   16'(busy), 16'(m_armed));
    check({tag, ".done"},   16'(frame_done), 16'(m_done));
    check({tag, ".ferr"},   16'(frame_err), 16'(m_done & m_ferr));
    check({tag, ".err"},    err_cnt, m_err);
    check({tag, ".words"},  word_cnt, m_words);
    check({tag, ".frames"}, frame_cnt, m_frames);
`ifdef INNER_SINK_ERR_CAPTURE_EN
    check({tag, ".cvld"},   16'(first_err_vld), 16'(m_cvld));
    check({tag, ".cidx"},   first_err_idx, m_cidx);
    check({tag, ".cexp"},   first_err_exp, m_cexp);
    check({tag, ".cgot"},   first_err_got, m_cgot);
`else
    check({tag, ".cvld"},   16'(first_err_vld), 16'h0);
    check({tag, ".cidx"},   first_err_idx, 16'h0);
    check({tag, ".cexp"},   first_err_exp, 16'h0);
    check({tag, ".cgot"},   first_err_got, 16'h0);
`endif
  endtask

  task automatic do_load(input logic [7:0] i, input logic [7:0] s, input logic [15:0] len);
    init_dat = i; step_dat = s; dat_length = len;
    update_flag = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("load.no_done", 16'(frame_done), 16'h0);
    end
    update_flag = 1'b0;
    tick();
    tick();
    m_init = i; m_step = s;
    m_lenw = (len / 2 == 0) ? 1 : len / 2;
    m_armed = 1'b1;
    model_clear();
    check_all("load");
  endtask

  task automatic send(input string tag, input logic [15:0] w);
    logic [15:0] e;
    din = w; en_in = 1'b1;
    tick();
    en_in = 1'b0;
    m_done = 1'b0;
    if (m_armed) begin
      e = exp_word(m_idx);
      m_words++;
      if (w != e) begin
        if (m_err != 16'hFFFF) m_err++;
        m_sticky = 1'b1;
        if (!m_cvld) begin
          m_cvld = 1'b1; m_cidx = 16'(m_idx); m_cexp = e; m_cgot = w;
        end
      end
      m_idx++;
      if (m_idx == m_lenw) begin
        m_done = 1'b1; m_ferr = m_sticky; m_sticky = 1'b0;
        m_idx = 0; m_frames++;
      end
    end
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      m_done = 1'b0;
      check("idle.done", 16'(frame_done), 16'h0);
    end
  endtask

  initial begin
    reset = 1'b1; update_flag = 1'b0; en_in = 1'b0; din = '0;
    init_dat = '0; step_dat = '0; dat_length = '0;
    m_armed = 1'b0; m_init = 0; m_step = 0; m_lenw = 1;
    model_clear();
    tick(); tick();
    reset = 1'b0;
    check_all("reset");

    // Basic frame.
    do_load(8'h10, 8'h01, 16'd8);
    send("basic0", 16'h1011);
    send("basic1", 16'h1213);
    send("basic2", 16'h1415);
    send("basic3", 16'h1617);
    idle(1);

    // Byte wrap with a gap.
    do_load(8'hFE, 8'h01, 16'd4);
    send("wrap0", 16'hFEFF);
    idle(3);
    send("wrap1", 16'h0001);

    // Corrupted word 2, then a later mismatch that must not overwrite capture.
    do_load(8'h10, 8'h01, 16'd8);
    send("corr0", 16'h1011);
    send("corr1", 16'h1213);
    send("corr2", 16'h1455);
    send("corr3", 16'h1617);
    send("corr4", 16'hBEEF);

    // Short lengths: every word is a frame.
    do_load(8'h10, 8'h01, 16'd0);
    for (int k = 0; k < 3; k++) send("len0", 16'h1011);
    do_load(8'h10, 8'h01, 16'd1);
    for (int k = 0; k < 3; k++) send("len1", 16'h1011);

    // Step with MSB set yields a constant word.
    do_load(8'h00, 8'h80, 16'd6);
    for (int k = 0; k < 3; k++) send("msb", 16'h0080);

    // Mid-frame reload aborts the frame, next frame checked from base.
    do_load(8'h10, 8'h01, 16'd8);
    send("mid0", 16'h1011);
    send("mid1", 16'h1213);
    do_load(8'h10, 8'h01, 16'd8);
    send("mid2", 16'h1011);
    send("mid3", 16'h1213);
    send("mid4", 16'h1415);
    send("mid5", 16'h1617);

    // Randomized configurations with corruption and gaps.
    for (int r = 0; r < 6; r++) begin
      do_load(8'($urandom), 8'($urandom), 16'($urandom_range(0, 20)));
      for (int k = 0; k < 2 * m_lenw + 3; k++) begin
        logic [15:0] w;
        w = exp_word(m_idx);
        if ($urandom_range(0, 3) == 0) w = w ^ (16'h1 << $urandom_range(0, 15));
        send("rand", w);
        idle($urandom_range(0, 2));
      end
    end

    // Reset during CHECK clears everything and disarms the checker.
    do_load(8'h10, 8'h01, 16'd8);
    send("rst0", 16'h1011);
    send("rst1", 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_armed = 1'b0;
    model_clear();
    check_all("rst");
    send("rst_drop0", 16'h1011);
    send("rst_drop1", 16'h1213);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
